math_multiplier_dot_accumulator: RTL and testbench



---
 rtl/math_multiplier_dot_accumulator.sv | 65 ++++++
 tb/tb_math_multiplier_dot_accumulator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/math_multiplier_dot_accumulator.sv
// math_multiplier_dot_accumulator: accumulates K consecutive 2N-bit products into a W-bit dot-product sum
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort of the current sum (discards any undrained result)
//   p, p_valid, p_ready product input handshake
//   sum, sum_valid,     completed K-term result handshake
//   sum_ready
//   ovf                 sticky carry out of bit W-1 during the current sum
//   cnt                 products accepted into the current sum
module math_multiplier_dot_accumulator #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int CW = 2,
    parameter int W  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [2*N-1:0] p,
    input  logic           p_valid,
    output logic           p_ready,
    output logic [W-1:0]   sum,
    output logic           sum_valid,
    input  logic           sum_ready,
    output logic           ovf,
    output logic [CW-1:0]  cnt
);
    logic [W-1:0]  sum_q, sum_d;
    logic          ovf_q, ovf_d;
    logic          sum_valid_q, sum_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc, drn, last;
    logic [W:0]    add;
    always_comb begin
        // a full result register accepts only if it drains on the same edge
        p_ready     = !clr && (!sum_valid_q || sum_ready);
        acc         = p_valid && p_ready;
        drn         = sum_valid_q && sum_ready;
        last        = cnt_q == CW'(K - 1);
        add         = {1'b0, sum_q} + (W + 1)'(p);
        // first term of a sum loads p directly so no stale sum or carry leaks in
        sum_d       = clr ? '0 : !acc ? sum_q : cnt_q == '0 ? W'(p) : add[W-1:0];
        ovf_d       = clr ? 1'b0 : !acc ? ovf_q : cnt_q == '0 ? 1'b0 : ovf_q | add[W];
        cnt_d       = clr ? '0 : !acc ? cnt_q : last ? '0 : cnt_q + 1'b1;
        // completion wins over a simultaneous drain
        sum_valid_d = clr ? 1'b0 : (acc && last) ? 1'b1 : drn ? 1'b0 : sum_valid_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            sum_valid_q <= sum_valid_d;
            cnt_q       <= cnt_d;
        end
    end
    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign sum_valid = sum_valid_q;
    assign cnt       = cnt_q;
endmodule

// File: tb/tb_math_multiplier_dot_accumulator.sv
// tb_math_multiplier_dot_accumulator: scoreboard bench driving a W=10 and a W=9 accumulator in lockstep
module tb_math_multiplier_dot_accumulator;
    localparam int N = 4, K = 4, CW = 2;
    logic clk = 0, rst_n = 1, clr = 0, p_valid = 0, sum_ready = 1;
    logic [2*N-1:0] p = '0;
    logic p_ready10, sv10, ovf10, p_ready9, sv9, ovf9;
    logic [9:0] sum10;
    logic [8:0] sum9;
    logic [CW-1:0] cnt10, cnt9;
    typedef struct packed {logic [9:0] s10; logic o10; logic [8:0] s9; logic o9;} exp_t;
    exp_t sbq[$];
    exp_t e;
    int vectors = 0, errors = 0, mcnt = 0, mtot = 0, cyc = 0;

    math_multiplier_dot_accumulator #(.N(N), .K(K), .CW(CW), .W(10)) u10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .p(p), .p_valid(p_valid), .p_ready(p_ready10),
        .sum(sum10), .sum_valid(sv10), .sum_ready(sum_ready), .ovf(ovf10), .cnt(cnt10));
    math_multiplier_dot_accumulator #(.N(N), .K(K), .CW(CW), .W(9)) u9 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .p(p), .p_valid(p_valid), .p_ready(p_ready9),
        .sum(sum9), .sum_valid(sv9), .sum_ready(sum_ready), .ovf(ovf9), .cnt(cnt9));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && !clr && sv10 && sum_ready) begin
            vectors++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected sum10=%0d", sum10);
            end else begin
                e = sbq.pop_front();
                if ({sum10, ovf10, sum9, ovf9} !== e) begin
                    errors++;
                    $display("FAIL drain got sum10=%0d ovf10=%0d sum9=%0d ovf9=%0d exp sum10=%0d ovf10=%0d sum9=%0d ovf9=%0d",
                             sum10, ovf10, sum9, ovf9, e.s10, e.o10, e.s9, e.o9);
                end
            end
        end
    end

    task automatic send(input logic [2*N-1:0] v);
        p = v;
        p_valid = 1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (p_ready10) begin
                @(posedge clk);
                #1;
                mtot = (mcnt == 0) ? int'(v) : mtot + int'(v);
                if (mcnt == K - 1) begin
                    sbq.push_back('{s10: 10'(mtot), o10: (mtot >= 1024), s9: 9'(mtot), o9: (mtot >= 512)});
                    mcnt = 0;
                end else mcnt++;
                return;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        errors++;
        $display("FAIL send_timeout p=%0d p_ready=%0d required 1", v, p_ready10);
    endtask

    task automatic idle(input int n);
        p_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        #3;
        vectors++;
        if ({sum10, sv10, ovf10, cnt10} !== '0) begin
            errors++;
            $display("FAIL reset_state sum=%0d sv=%0d ovf=%0d cnt=%0d required 0", sum10, sv10, ovf10, cnt10);
        end
        @(posedge clk);
        #1 rst_n = 1;
        #1;
        vectors++;
        if (p_ready10 !== 1'b1) begin
            errors++;
            $display("FAIL reset_p_ready got %0d required 1", p_ready10);
        end
        send(7);
        send(7);
        p_valid = 0;
        vectors++;
        if (cnt10 !== 2'd2 || sum10 !== 10'd14) begin
            errors++;
            $display("FAIL pre_reset cnt=%0d sum=%0d required 2 14", cnt10, sum10);
        end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({sum10, sv10, ovf10, cnt10} !== '0) begin
            errors++;
            $display("FAIL async_reset sum=%0d sv=%0d ovf=%0d cnt=%0d required 0", sum10, sv10, ovf10, cnt10);
        end
        mcnt = 0;
        @(posedge clk);
        #1 rst_n = 1;
        send(1); send(2); send(3); send(4);
        idle(2);
    endtask

    task automatic test_full_scale;
        int hi;
        logic first;
        repeat (4) send(225);
        p_valid = 0;
        @(negedge clk);
        first = sv10;
        hi = int'(sv10);
        vectors++;
        if (sum10 !== 10'd900 || ovf10 !== 1'b0) begin
            errors++;
            $display("FAIL full_scale sum=%0d ovf=%0d required 900 0", sum10, ovf10);
        end
        repeat (3) begin
            @(negedge clk);
            hi += int'(sv10);
        end
        vectors++;
        if (first !== 1'b1 || hi != 1) begin
            errors++;
            $display("FAIL full_scale_pulse first=%0d cycles=%0d required 1 1", first, hi);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        repeat (4) send(225);
        vectors++;
        if (sum9 !== 9'd388 || ovf9 !== 1'b1 || sv9 !== 1'b1) begin
            errors++;
            $display("FAIL overflow sum9=%0d ovf9=%0d sv9=%0d required 388 1 1", sum9, ovf9, sv9);
        end
        repeat (4) send(1);
        vectors++;
        if (sum9 !== 9'd4 || ovf9 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_recover sum9=%0d ovf9=%0d required 4 0", sum9, ovf9);
        end
        idle(2);
    endtask

    task automatic test_backpressure;
        int c0;
        sum_ready = 0;
        send(1); send(2); send(3); send(4);
        p = 9;
        p_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (p_ready10 !== 1'b0 || sum10 !== 10'd10 || sv10 !== 1'b1) begin
                errors++;
                $display("FAIL backpressure cyc%0d p_ready=%0d sum=%0d sv=%0d required 0 10 1", i, p_ready10, sum10, sv10);
            end
        end
        @(posedge clk);
        #1 sum_ready = 1;
        c0 = cyc;
        send(9);
        vectors++;
        if (cnt10 !== 2'd1 || sum10 !== 10'd9 || sv10 !== 1'b0 || cyc - c0 != 1) begin
            errors++;
            $display("FAIL release cnt=%0d sum=%0d sv=%0d edges=%0d required 1 9 0 1", cnt10, sum10, sv10, cyc - c0);
        end
        send(0); send(0); send(0);
        idle(2);
    endtask

    task automatic test_streaming;
        int c0;
        c0 = 0;
        for (int i = 1; i <= 12; i++) begin
            send(8'(i));
            if (i == 1) c0 = cyc;
            vectors++;
            if (sv10 !== (i % 4 == 0) || (i % 4 == 0 && sum10 !== 10'(4 * i - 6))) begin
                errors++;
                $display("FAIL stream i=%0d sv=%0d sum=%0d required %0d %0d", i, sv10, sum10, (i % 4 == 0), 4 * i - 6);
            end
        end
        vectors++;
        if (cyc - c0 != 11) begin
            errors++;
            $display("FAIL stream_throughput edges=%0d required 11", cyc - c0);
        end
        idle(2);
    endtask

    task automatic test_clr;
        send(1); send(2); send(3);
        vectors++;
        if (cnt10 !== 2'd3 || sum10 !== 10'd6) begin
            errors++;
            $display("FAIL pre_clr cnt=%0d sum=%0d required 3 6", cnt10, sum10);
        end
        clr = 1;
        p = 9;
        p_valid = 1;
        @(negedge clk);
        vectors++;
        if (p_ready10 !== 1'b0) begin
            errors++;
            $display("FAIL clr_p_ready got %0d required 0", p_ready10);
        end
        @(posedge clk);
        #1 clr = 0;
        p_valid = 0;
        mcnt = 0;
        vectors++;
        if (cnt10 !== '0 || sum10 !== '0 || sv10 !== 1'b0) begin
            errors++;
            $display("FAIL clr cnt=%0d sum=%0d sv=%0d required 0 0 0", cnt10, sum10, sv10);
        end
        repeat (4) send(5);
        vectors++;
        if (sum10 !== 10'd20 || sv10 !== 1'b1) begin
            errors++;
            $display("FAIL post_clr sum=%0d sv=%0d required 20 1", sum10, sv10);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_overflow();
        test_backpressure();
        test_streaming();
        test_clr();
        idle(3);
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL undrained_results got %0d required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
